display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl_pkg.sv | 41 ++++
 rtl/display_scan_ctrl_if.sv | 25 ++
 rtl/display_scan_ctrl_tick_divider.sv | 27 ++
 rtl/display_scan_ctrl.sv | 88 ++++++++
 tb/tb_display_scan_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// Shared slot numbering, edit-field encodings and digit-mask helper for the scan controller.
// Pure definitions; no state and no handshaking.
package display_pkg;

    localparam logic [2:0] SLOT_D0   = 3'd0;
    localparam logic [2:0] SLOT_D1   = 3'd2;
    localparam logic [2:0] SLOT_D2   = 3'd4;
    localparam logic [2:0] SLOT_D3   = 3'd6;
    localparam logic [2:0] SLOT_LAST = 3'd7;

    localparam logic [3:0] MASK_ALL = 4'b1111;

    typedef enum logic [1:0] {
        EDIT_NONE  = 2'd0,
        EDIT_RIGHT = 2'd1,
        EDIT_LEFT  = 2'd2,
        EDIT_ALL   = 2'd3
    } edit_e;

    // Bit 3 is the left tens digit, so leading-zero blanking only ever touches it.
    function automatic logic [3:0] digit_mask(input logic       blink_off,
                                              input logic [1:0] edit,
                                              input logic       lz,
                                              input logic [5:0] left,
                                              input logic       en);
        logic [3:0] m;
        m = MASK_ALL;
        if (blink_off) begin
            case (edit_e'(edit))
                EDIT_RIGHT: m[1:0] = 2'b00;
                EDIT_LEFT:  m[3:2] = 2'b00;
                EDIT_ALL:   m      = 4'b0000;
                default:    m      = MASK_ALL;
            endcase
        end
        if (lz && (left < 6'd10)) m[3] = 1'b0;
        if (!en) m = 4'b0000;
        return m;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bundles the time fields, display controls and scan outputs of the display path.
// slave = the scan controller, master = whoever supplies the time and controls.
interface display_scan_if;
    logic [5:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    logic        mode_sel;
    logic [1:0]  edit_field;
    logic        lz_blank;
    logic        display_en;
    logic [11:0] data_show;
    logic [2:0]  byte_status;
    logic [3:0]  segment_byte_control;
    logic        frame_tick;

    modport master (
        output hour, minute, second, mode_sel, edit_field, lz_blank, display_en,
        input  data_show, byte_status, segment_byte_control, frame_tick
    );

    modport slave (
        input  hour, minute, second, mode_sel, edit_field, lz_blank, display_en,
        output data_show, byte_status, segment_byte_control, frame_tick
    );
endinterface

// File: rtl/display_scan_ctrl_tick_divider.sv
// Modulo-DIV event counter: tc is combinational (en && count==DIV-1), count updates next edge.
// clr has priority over en; free-running, no backpressure.
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tc
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tc = en && (count == LAST);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) count <= '0;
            else               count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// Scan slot sequencer plus per-frame content/mask snapshot for the 4-digit display mux.
// Outputs registered; frame content changes only at the 7->0 slot wrap, no backpressure.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 32
) (
    input  logic          clock,
    input  logic          reset,
    display_scan_if.slave bus
);
    logic        slot_adv;
    logic        fb;
    logic        blink_tc;
    logic        edit_chg;
    logic        phase;
    logic        phase_nxt;
    logic [1:0]  edit_q;
    logic [2:0]  slot;
    logic [11:0] data_q;
    logic [3:0]  seg_q;
    logic        tick_q;
    logic [5:0]  left_sel;
    logic [11:0] data_nxt;
    logic [3:0]  mask_nxt;

    tick_divider #(.DIV(SCAN_DIV)) u_prescaler (
        .clock (clock),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .tc    (slot_adv)
    );

    assign fb       = slot_adv && (slot == SLOT_LAST);
    assign edit_chg = (bus.edit_field != edit_q);

    tick_divider #(.DIV(BLINK_DIV)) u_blink (
        .clock (clock),
        .reset (reset),
        .en    (fb),
        .clr   (edit_chg),
        .tc    (blink_tc)
    );

    // An edit change restarts the blink cycle in the visible phase, even on a frame boundary.
    always_comb begin
        phase_nxt = phase;
        if (edit_chg)      phase_nxt = 1'b0;
        else if (blink_tc) phase_nxt = ~phase;
    end

    always_comb begin
        left_sel = bus.hour;
        data_nxt = {bus.hour, bus.minute};
        if (bus.mode_sel) begin
            left_sel = bus.minute;
            data_nxt = {bus.minute, bus.second};
        end
        mask_nxt = digit_mask(phase_nxt, edit_q, bus.lz_blank, left_sel, bus.display_en);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot   <= 3'd0;
            data_q <= 12'd0;
            seg_q  <= 4'b0000;
            tick_q <= 1'b0;
            phase  <= 1'b0;
            edit_q <= 2'd0;
        end else begin
            if (slot_adv) slot <= slot + 3'd1;
            tick_q <= fb;
            phase  <= phase_nxt;
            edit_q <= bus.edit_field;
            if (fb) data_q <= data_nxt;
            // Disabling blanks immediately; enabling waits for a clean frame start.
            if (!bus.display_en) seg_q <= 4'b0000;
            else if (fb)         seg_q <= mask_nxt;
        end
    end

    assign bus.byte_status          = slot;
    assign bus.data_show            = data_q;
    assign bus.segment_byte_control = seg_q;
    assign bus.frame_tick           = tick_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Cycle-indexed model of the scan controller checked every cycle, plus pinned literal checkpoints.
module tb_display_scan_ctrl;
    import display_pkg::*;

    localparam int SD = 4;
    localparam int BD = 2;
    localparam int FR = 8 * SD;

    logic clock = 1'b0;
    logic reset = 1'b1;

    display_scan_if bus();

    display_scan_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Model state: m_t = clock edges since the last reset edge (cycle index),
    // m_k = frame boundaries since the blink cycle was last restarted.
    int          m_t = 0;
    int          m_k = 0;
    logic [1:0]  m_edit = 2'd0;
    logic [11:0] e_data = 12'd0;
    logic [3:0]  e_mask = 4'd0;
    logic        e_tick = 1'b0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, m_t, act, req);
        end
    endtask

    function automatic logic [3:0] model_mask(input bit off, input logic [1:0] ed,
                                              input logic lz, input logic [5:0] left);
        logic [3:0] m;
        m = 4'b1111;
        if (off && ed[0]) m[1:0] = 2'b00;
        if (off && ed[1]) m[3:2] = 2'b00;
        if (lz && left < 6'd10) m[3] = 1'b0;
        return m;
    endfunction

    // Per-cycle compare and model advance, at the falling edge.
    initial begin : compare
        bit         fbm;
        bit         chg;
        logic [5:0] left;
        @(posedge clock);
        forever begin
            @(negedge clock);
            chk("byte_status", 12'(bus.byte_status), 12'((m_t / SD) % 8));
            chk("frame_tick",  12'(bus.frame_tick), 12'(e_tick));
            chk("data_show",   bus.data_show, e_data);
            chk("seg_ctrl",    12'(bus.segment_byte_control), 12'(e_mask));
            if (reset) begin
                m_t = 0; m_k = 0; m_edit = 2'd0;
                e_data = 12'd0; e_mask = 4'd0; e_tick = 1'b0;
            end else begin
                fbm = ((m_t % FR) == FR - 1);
                chg = (bus.edit_field != m_edit);
                if (chg)      m_k = 0;
                else if (fbm) m_k = m_k + 1;
                if (fbm) begin
                    left   = bus.mode_sel ? bus.minute : bus.hour;
                    e_data = bus.mode_sel ? {bus.minute, bus.second} : {bus.hour, bus.minute};
                    e_mask = model_mask(((m_k / BD) % 2) == 1, m_edit, bus.lz_blank, left);
                end
                if (!bus.display_en) e_mask = 4'd0;
                e_tick = fbm;
                m_edit = bus.edit_field;
                m_t    = m_t + 1;
            end
        end
    end

    task automatic step_to(input int n);
        int budget;
        budget = 2000;
        while (m_t < n && budget > 0) begin
            @(posedge clock);
            #2;
            budget--;
        end
        tests++;
        if (m_t != n) begin
            fails++;
            $display("FAIL step_to actual=%0d required=%0d", m_t, n);
        end
    endtask

    initial begin : stimulus
        bus.hour = 6'd12; bus.minute = 6'd34; bus.second = 6'd56;
        bus.mode_sel = 1'b0; bus.edit_field = 2'd0;
        bus.lz_blank = 1'b0; bus.display_en = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("rst_bs",   12'(bus.byte_status), 12'd0);
        chk("rst_seg",  12'(bus.segment_byte_control), 12'd0);
        chk("rst_data", bus.data_show, 12'd0);
        chk("rst_tick", 12'(bus.frame_tick), 12'd0);

        step_to(5);   chk("bs_t5", 12'(bus.byte_status), 12'd1);
        step_to(31);  chk("bs_t31", 12'(bus.byte_status), 12'(SLOT_LAST));
                      chk("seg_blank_t31", 12'(bus.segment_byte_control), 12'd0);
                      chk("tick_t31", 12'(bus.frame_tick), 12'd0);
        step_to(32);  chk("tick_t32", 12'(bus.frame_tick), 12'd1);
                      chk("bs_t32", 12'(bus.byte_status), 12'(SLOT_D0));
                      chk("data_hm", bus.data_show, {6'd12, 6'd34});
                      chk("seg_t32", 12'(bus.segment_byte_control), 12'b1111);
        step_to(33);  chk("tick_t33", 12'(bus.frame_tick), 12'd0);

        step_to(40);  bus.mode_sel = 1'b1;
        step_to(63);  chk("data_hold", bus.data_show, {6'd12, 6'd34});
        step_to(64);  chk("data_ms", bus.data_show, {6'd34, 6'd56});
                      bus.mode_sel = 1'b0; bus.edit_field = 2'd1;

        step_to(96);  chk("blink_f1", 12'(bus.segment_byte_control), 12'b1111);
        step_to(128); chk("blink_f2", 12'(bus.segment_byte_control), 12'b1100);
        step_to(160); chk("blink_f3", 12'(bus.segment_byte_control), 12'b1100);
        step_to(192); chk("blink_f4", 12'(bus.segment_byte_control), 12'b1111);
        step_to(224); chk("blink_f5", 12'(bus.segment_byte_control), 12'b1111);
        step_to(288); chk("blink_off", 12'(bus.segment_byte_control), 12'b1100);
        step_to(300); bus.edit_field = 2'd2;
        step_to(320); chk("edit_restart", 12'(bus.segment_byte_control), 12'b1111);
        step_to(352); chk("edit_left_off", 12'(bus.segment_byte_control), 12'b0011);

        step_to(360); bus.edit_field = 2'd0; bus.lz_blank = 1'b1; bus.hour = 6'd7;
        step_to(384); chk("lz_7", 12'(bus.segment_byte_control), 12'b0111);
        step_to(390); bus.hour = 6'd10;
        step_to(400); chk("lz_hold", 12'(bus.segment_byte_control), 12'b0111);
        step_to(416); chk("lz_10", 12'(bus.segment_byte_control), 12'b1111);

        step_to(433); chk("bs_slot4", 12'(bus.byte_status), 12'(SLOT_D2));
                      bus.display_en = 1'b0;
        step_to(434); chk("en_off", 12'(bus.segment_byte_control), 12'b0000);
        step_to(440); bus.display_en = 1'b1;
        step_to(447); chk("en_wait", 12'(bus.segment_byte_control), 12'b0000);
        step_to(448); chk("en_back", 12'(bus.segment_byte_control), 12'b1111);

        step_to(450); bus.hour = 6'd63;
        step_to(480); chk("data_63", bus.data_show, {6'd63, 6'd34});
                      chk("seg_63", 12'(bus.segment_byte_control), 12'b1111);

        step_to(501); chk("bs_slot5", 12'(bus.byte_status), 12'd5);
                      reset = 1'b1;
        @(posedge clock); #2;
        chk("mid_rst_bs",   12'(bus.byte_status), 12'd0);
        chk("mid_rst_seg",  12'(bus.segment_byte_control), 12'd0);
        chk("mid_rst_data", bus.data_show, 12'd0);
        @(posedge clock); #1 reset = 1'b0;
        #1;
        step_to(31);  chk("post_rst_seg", 12'(bus.segment_byte_control), 12'd0);
        step_to(32);  chk("post_rst_data", bus.data_show, {6'd63, 6'd34});
                      chk("post_rst_tick", 12'(bus.frame_tick), 12'd1);
        step_to(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
